// File: rtl/exu_pc_seq.sv
// exu_pc_seq -- multi-cycle next-PC sequencer.
//
// Owns the PC register. Presents it to the IFU over a fetch valid/ready
// handshake, then waits for resolved control-flow info from the EXU over a
// second handshake and computes the next PC. Handles all six RV32I branch
// types, jal, jalr, ebreak halt and misaligned-target detection.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   fetch_pc       current PC presented to the IFU
//   fetch_valid    fetch_pc valid (FETCH state only)
//   fetch_ready    IFU accepts fetch_pc
//   exu_valid      EXU control-flow info valid
//   exu_ready      unit accepts EXU info (EXEC state only)
//   jump_op        0 SEQ,1 JAL,2 JALR,3 BEQ,4 BNE,5 BLT,6 BGE,7 BLTU,8 BGEU, else SEQ
//   src1, src2     rs1/rs2 values
//   imm            sign-extended immediate
//   halt_req       ebreak retired with this EXU transfer
//   redirect       one-cycle pulse when the committed next PC != PC+4
//   halted         unit is in HALT
//   err            unit is in ERR (misaligned target)
//
// Optional feature macro: EXU_PC_TRAP_EN
//   Adds trap_req, mret, mtvec, mepc inputs and the exc output. Traps and
//   mret redirect to mtvec/mepc; a misaligned target vectors to mtvec with
//   exc pulsed instead of entering ERR.

module exu_pc_seq #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [3:0]      jump_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  input  logic            halt_req,
  output logic            redirect,
  output logic            halted,
  output logic            err
`ifdef EXU_PC_TRAP_EN
  ,
  input  logic            trap_req,
  input  logic            mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            exc
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [3:0] OP_JAL  = 4'd1;
  localparam logic [3:0] OP_JALR = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_BLT  = 4'd5;
  localparam logic [3:0] OP_BGE  = 4'd6;
  localparam logic [3:0] OP_BLTU = 4'd7;
  localparam logic [3:0] OP_BGEU = 4'd8;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            misalign;

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_imm   = pc + imm;
  assign jalr_tgt = (src1 + imm) & ~XLEN'(1);

  always_comb begin
    taken = 1'b0;
    unique case (jump_op)
      OP_BEQ:  taken = (src1 == src2);
      OP_BNE:  taken = (src1 != src2);
      OP_BLT:  taken = ($signed(src1) <  $signed(src2));
      OP_BGE:  taken = ($signed(src1) >= $signed(src2));
      OP_BLTU: taken = (src1 <  src2);
      OP_BGEU: taken = (src1 >= src2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target = pc_plus4;
    unique case (jump_op)
      OP_JAL:  target = pc_imm;
      OP_JALR: target = jalr_tgt;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
               target = taken ? pc_imm : pc_plus4;
      default: target = pc_plus4;
    endcase
  end

  // No C extension: any target not on a 4-byte boundary is illegal.
  assign misalign = (target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      redirect <= 1'b0;
`ifdef EXU_PC_TRAP_EN
      exc      <= 1'b0;
`endif
    end else begin
      redirect <= 1'b0;
`ifdef EXU_PC_TRAP_EN
      exc      <= 1'b0;
`endif
      case (state)
        S_FETCH: begin
          if (fetch_ready) state <= S_EXEC;
        end
        S_EXEC: begin
          if (exu_valid) begin
            if (halt_req) begin
              state <= S_HALT;
`ifdef EXU_PC_TRAP_EN
            end else if (trap_req) begin
              pc       <= mtvec & ~XLEN'(3);
              redirect <= 1'b1;
              state    <= S_FETCH;
            end else if (mret) begin
              pc       <= mepc & ~XLEN'(3);
              redirect <= 1'b1;
              state    <= S_FETCH;
            end else if (misalign) begin
              pc       <= mtvec & ~XLEN'(3);
              redirect <= 1'b1;
              exc      <= 1'b1;
              state    <= S_FETCH;
`else
            end else if (misalign) begin
              state <= S_ERR;
`endif
            end else begin
              pc       <= target;
              redirect <= (target != pc_plus4);
              state    <= S_FETCH;
            end
          end
        end
        default: state <= state;  // HALT and ERR are absorbing
      endcase
    end
  end

  assign fetch_pc    = pc;
  // Gated by rst so that every 1-bit output reads 0 while reset is held.
  assign fetch_valid = (state == S_FETCH) && !rst;
  assign exu_ready   = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign err         = (state == S_ERR);

endmodule
